// File: rtl/microsequencer.sv
// Next-state sequencer for the microprogrammed control unit: picks the next
// microstore address from the control word, stalls on WAIT and traps on faults.
//
// ns_sel | meaning
// 000    | ENCODE : jump to opcode entry state
// 001    | FETCH  : jump to fetch state
// 010    | CR     : jump to control-register target
// 011    | INCR   : fall through to current+1
// 100    | CBR    : c ? cr_addr : current+1
// 101    | CENC   : c ? encoder_addr : cr_addr
// 110    | WAIT   : c ? current+1 : stay (stalled)
// 111    | -      : reserved, traps to fault state
module microsequencer #(
    parameter int STATE_W     = 10,
    parameter int NUM_STATES  = 126,
    parameter int FETCH_STATE = 0,
    parameter int FAULT_STATE = 125,
    parameter int TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic [2:0]         ns_sel,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [STATE_W-1:0] encoder_addr,
    input  logic               moc,
    input  logic               cond_in,
    input  logic               irq,
    output logic [STATE_W-1:0] next_state,
    output logic [STATE_W-1:0] current_state,
    output logic               stalled,
    output logic               timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        NS_ENCODE = 3'b000,
        NS_FETCH  = 3'b001,
        NS_CR     = 3'b010,
        NS_INCR   = 3'b011,
        NS_CBR    = 3'b100,
        NS_CENC   = 3'b101,
        NS_WAIT   = 3'b110,
        NS_RSVD   = 3'b111
    } ns_op_t;

    ns_op_t             op;
    logic               sel_cond;
    logic               c;
    logic [STATE_W:0]   inc;
    logic [STATE_W:0]   target;
    logic [STATE_W-1:0] legal_target;
    logic               waiting;
    logic               wait_expired;
    logic [CNT_W-1:0]   wait_cnt;

    assign op = ns_op_t'(ns_sel);

    always_comb begin
        sel_cond     = 1'b1;
        target       = '0;
        next_state   = STATE_W'(FETCH_STATE);
        stalled      = 1'b0;
        timeout      = 1'b0;

        case (cond_sel)
            2'b00:   sel_cond = moc;
            2'b01:   sel_cond = cond_in;
            2'b10:   sel_cond = irq;
            default: sel_cond = 1'b1;
        endcase
        c   = sel_cond ^ inv;
        // one extra bit so current+1 from the top state cannot wrap to a legal address
        inc = {1'b0, current_state} + (STATE_W+1)'(1);

        case (op)
            NS_ENCODE: target = {1'b0, encoder_addr};
            NS_FETCH:  target = (STATE_W+1)'(FETCH_STATE);
            NS_CR:     target = {1'b0, cr_addr};
            NS_INCR:   target = inc;
            NS_CBR:    target = c ? {1'b0, cr_addr} : inc;
            NS_CENC:   target = c ? {1'b0, encoder_addr} : {1'b0, cr_addr};
            NS_WAIT:   target = c ? inc : {1'b0, current_state};
            default:   target = (STATE_W+1)'(FAULT_STATE);
        endcase

        legal_target = (target >= (STATE_W+1)'(NUM_STATES)) ? STATE_W'(FAULT_STATE)
                                                             : target[STATE_W-1:0];
        waiting      = (op == NS_WAIT) && !c;
        wait_expired = waiting && (wait_cnt == CNT_W'(TIMEOUT-1));

        if (reset) begin
            next_state = STATE_W'(FETCH_STATE);
        end else if (hold) begin
            next_state = current_state;
            stalled    = waiting;
        end else if (wait_expired) begin
            next_state = STATE_W'(FAULT_STATE);
            stalled    = 1'b1;
            timeout    = 1'b1;
        end else begin
            next_state = legal_target;
            stalled    = waiting;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state <= STATE_W'(FETCH_STATE);
            wait_cnt      <= '0;
        end else if (!hold) begin
            current_state <= next_state;
            wait_cnt      <= (waiting && !wait_expired) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: a behavioural model checked against the DUT on every
// negative edge, plus directed scenarios with hand-computed expectations.
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic [2:0] ns_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic [9:0] cr_addr;
    logic [9:0] encoder_addr;
    logic       moc;
    logic       cond_in;
    logic       irq;
    logic [9:0] next_state;
    logic [9:0] current_state;
    logic       stalled;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;
    int m_state = 0;
    int m_cnt   = 0;

    microsequencer dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .ns_sel        (ns_sel),
        .inv           (inv),
        .cond_sel      (cond_sel),
        .cr_addr       (cr_addr),
        .encoder_addr  (encoder_addr),
        .moc           (moc),
        .cond_in       (cond_in),
        .irq           (irq),
        .next_state    (next_state),
        .current_state (current_state),
        .stalled       (stalled),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Expected behaviour from the rules: state in, next/stall/timeout/wait-flag out.
    function automatic void model(input int st, input int cnt, output int ns,
                                  output bit stl, output bit to, output bit wt);
        bit cnd;
        int t;
        cnd = (cond_sel == 0) ? moc : (cond_sel == 1) ? cond_in : (cond_sel == 2) ? irq : 1'b1;
        cnd = cnd ^ inv;
        case (ns_sel)
            0: t = encoder_addr;
            1: t = 0;
            2: t = cr_addr;
            3: t = st + 1;
            4: t = cnd ? int'(cr_addr) : st + 1;
            5: t = cnd ? int'(encoder_addr) : int'(cr_addr);
            6: t = cnd ? st + 1 : st;
            default: t = 125;
        endcase
        if (t > 125) t = 125;
        wt  = (ns_sel == 6) && !cnd;
        to  = 0;
        stl = wt;
        ns  = t;
        if (reset) begin
            ns = 0; stl = 0;
        end else if (hold) begin
            ns = st;
        end else if (wt && cnt == 15) begin
            ns = 125; to = 1;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        int ns; bit stl, to, wt;
        if (reset) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (!hold) begin
            model(m_state, m_cnt, ns, stl, to, wt);
            m_state = ns;
            m_cnt   = (wt && !to) ? m_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        int ns; bit stl, to, wt;
        model(m_state, m_cnt, ns, stl, to, wt);
        check("model.current_state", int'(current_state), m_state);
        check("model.next_state", int'(next_state), ns);
        check("model.stalled", int'(stalled), int'(stl));
        check("model.timeout", int'(timeout), int'(to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input int ns, input int iv, input int cs, input int cr, input int enc);
        ns_sel = 3'(ns); inv = iv[0]; cond_sel = 2'(cs);
        cr_addr = 10'(cr); encoder_addr = 10'(enc);
        #1;
    endtask

    task automatic jump(input int st);
        ctl(2, 0, 3, st, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; moc = 1'b0; cond_in = 1'b0; irq = 1'b0;
        ns_sel = 3'd3; inv = 1'b0; cond_sel = 2'd0; cr_addr = '0; encoder_addr = '0;
        tick(); tick();
        check("reset.next_state", int'(next_state), 0);
        check("reset.current_state", int'(current_state), 0);
        check("reset.stalled", int'(stalled), 0);

        // Scenario 1: ENCODE after reset
        reset = 1'b0;
        ctl(0, 0, 0, 0, 12);
        check("enc.next_state", int'(next_state), 12);
        tick();
        check("enc.current_state", int'(current_state), 12);

        // Scenario 2: CBR from state 3
        jump(3);
        cond_in = 1'b1; ctl(4, 0, 1, 42, 0);
        check("cbr.taken", int'(next_state), 42);
        cond_in = 1'b0; ctl(4, 0, 1, 42, 0);
        check("cbr.not_taken", int'(next_state), 4);
        ctl(4, 1, 1, 42, 0);
        check("cbr.inverted", int'(next_state), 42);
        tick();

        // Scenario 3: WAIT on MOC at state 82
        jump(82);
        moc = 1'b0; ctl(6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("wait.stalled", int'(stalled), 1);
            check("wait.held", int'(current_state), 82);
            tick();
        end
        moc = 1'b1; #1;
        check("wait.released", int'(stalled), 0);
        tick();
        check("wait.advanced", int'(current_state), 83);

        // Scenario 4: WAIT time-out, twice to show the counter restarts from zero
        moc = 1'b0; ctl(6, 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 16; i++) begin
                check("to.pulse", int'(timeout), (i == 16) ? 1 : 0);
                tick();
            end
            check("to.fault", int'(current_state), 125);
        end
        check("to.after", int'(timeout), 0);

        // Scenario 5: illegal targets
        jump(124);
        ctl(3, 0, 0, 0, 0);
        check("incr.124", int'(next_state), 125);
        tick();
        check("incr.cur125", int'(current_state), 125);
        check("incr.nowrap", int'(next_state), 125);
        ctl(2, 0, 0, 200, 0);
        check("cr.illegal", int'(next_state), 125);
        ctl(0, 0, 0, 0, 300);
        check("enc.illegal", int'(next_state), 125);
        ctl(7, 0, 0, 5, 5);
        check("reserved", int'(next_state), 125);

        // Remaining decode paths
        jump(30);
        ctl(5, 0, 3, 40, 7);
        check("cenc.taken", int'(next_state), 7);
        ctl(5, 1, 3, 40, 7);
        check("cenc.not_taken", int'(next_state), 40);
        irq = 1'b1; ctl(4, 0, 2, 50, 0);
        check("cbr.irq", int'(next_state), 50);
        ctl(1, 0, 0, 0, 0);
        check("fetch", int'(next_state), 0);
        tick();
        irq = 1'b0;

        // Scenario 6: hold freezes a CR jump
        jump(10);
        hold = 1'b1; ctl(2, 0, 0, 20, 0);
        for (int i = 0; i < 4; i++) begin
            check("hold.next", int'(next_state), 10);
            check("hold.timeout", int'(timeout), 0);
            tick();
            check("hold.cur", int'(current_state), 10);
        end
        hold = 1'b0; #1;
        check("hold.release", int'(next_state), 20);
        tick();
        check("hold.jumped", int'(current_state), 20);

        // Hold at the last stalled cycle suppresses the time-out until released
        moc = 1'b0; ctl(6, 0, 0, 0, 0);
        repeat (15) tick();
        hold = 1'b1; #1;
        check("hold.wait.stalled", int'(stalled), 1);
        check("hold.wait.no_to", int'(timeout), 0);
        tick(); tick();
        hold = 1'b0; #1;
        check("hold.wait.to", int'(timeout), 1);
        tick();
        check("hold.wait.fault", int'(current_state), 125);

        // Reset mid-WAIT, then a full time-out window shows the counter cleared
        jump(60);
        ctl(6, 0, 0, 0, 0);
        repeat (7) tick();
        reset = 1'b1; #1;
        check("rst.async.cur", int'(current_state), 0);
        check("rst.async.next", int'(next_state), 0);
        check("rst.async.stall", int'(stalled), 0);
        tick();
        reset = 1'b0; #1;
        for (int i = 1; i <= 16; i++) begin
            check("rst.to.pulse", int'(timeout), (i == 16) ? 1 : 0);
            tick();
        end
        check("rst.to.fault", int'(current_state), 125);

        ctl(3, 0, 0, 0, 0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
